// File: rtl/en_cond_pkg.sv
// Shared types and helpers for the enable conditioner.
package en_cond_pkg;

  typedef enum logic [1:0] {LO, DEB_HI, HI, DEB_LO} en_state_t;

  // Width of a counter that must hold values 0..cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/en_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, async reset to 0.
module en_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw bit through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/enable_conditioner.sv
// Enable conditioner: synchronise, debounce, then registered level and
// one-cycle edge pulses, plus a saturating count of rejected glitches.
// Optional high-time counter on hi_time is built when EN_COND_HITIME_EN is
// defined; otherwise hi_time is tied to 0.
module enable_conditioner
  import en_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 8,
  parameter int unsigned HT_W            = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_raw,
  output logic                en_level,
  output logic                en_rise,
  output logic                en_fall,
  output logic                en_change,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic [HT_W-1:0]     hi_time
);

  localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             en_s;
  en_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             glitch_inc;
  logic             rise_n, fall_n;

  en_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (en_raw),
    .q  (en_s)
  );

  // State and stable-sample counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LO;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Debounce next-state logic; edge pulses are decided here and registered below.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    glitch_inc = 1'b0;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    case (state)
      LO: begin
        if (en_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = HI;
            rise_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = DEB_HI;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      DEB_HI: begin
        if (!en_s) begin
          state_n    = LO;
          glitch_inc = 1'b1;
          cnt_n      = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HI;
          rise_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HI: begin
        if (!en_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = LO;
            fall_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            state_n = DEB_LO;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      DEB_LO: begin
        if (en_s) begin
          state_n    = HI;
          glitch_inc = 1'b1;
          cnt_n      = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = LO;
          fall_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = LO;
        cnt_n   = '0;
      end
    endcase
  end

  // Registered level and one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_level  <= 1'b0;
      en_rise   <= 1'b0;
      en_fall   <= 1'b0;
      en_change <= 1'b0;
    end else begin
      if (rise_n)      en_level <= 1'b1;
      else if (fall_n) en_level <= 1'b0;
      en_rise   <= rise_n;
      en_fall   <= fall_n;
      en_change <= rise_n | fall_n;
    end
  end

  // Saturating count of rejected transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                glitch_cnt <= '0;
    else if (glitch_inc && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
  end

`ifdef EN_COND_HITIME_EN
  // Cycles spent high: 1 on the rise cycle, counts while high, holds after fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          hi_time <= '0;
    else if (rise_n)                                  hi_time <= HT_W'(1);
    else if (en_level && !fall_n && hi_time != '1)    hi_time <= hi_time + 1'b1;
  end
`else
  assign hi_time = '0;
`endif

endmodule

// File: tb/tb_enable_conditioner.sv
// Self-checking bench for enable_conditioner (default S=2, D=4).
module tb_enable_conditioner;

  localparam int unsigned S  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned GW = 8;
  localparam int unsigned HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_raw;
  logic          en_level, en_rise, en_fall, en_change;
  logic [GW-1:0] glitch_cnt;
  logic [HW-1:0] hi_time;

  typedef struct packed {
    logic          level;
    logic          rise;
    logic          fall;
    logic          change;
    logic [GW-1:0] glitch;
    logic [HW-1:0] hi;
  } obs_t;

  obs_t sb[$];
  obs_t exp_v;
  obs_t got;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model: level flips after D consecutive synced samples that
  // differ from it; a broken run counts as one glitch.
  logic [S-1:0]  m_sync;
  logic          m_level;
  int unsigned   m_run;
  logic [GW-1:0] m_glitch;
  logic [HW-1:0] m_hi;

  enable_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .GLITCH_W       (GW),
    .HT_W           (HW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_raw    (en_raw),
    .en_level  (en_level),
    .en_rise   (en_rise),
    .en_fall   (en_fall),
    .en_change (en_change),
    .glitch_cnt(glitch_cnt),
    .hi_time   (hi_time)
  );

  always #5 clk = ~clk;

  assign got = {en_level, en_rise, en_fall, en_change, glitch_cnt, hi_time};

  task automatic model_reset();
    m_sync   = '0;
    m_level  = 1'b0;
    m_run    = 0;
    m_glitch = '0;
    m_hi     = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic raw);
    obs_t e;
    logic s;
    e      = '0;
    s      = m_sync[S-1];
    m_sync = {m_sync[S-2:0], raw};
    if (s !== m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        e.rise  = s;
        e.fall  = !s;
        m_run   = 0;
      end
    end else begin
      if (m_run != 0 && m_glitch != '1) m_glitch = m_glitch + 1'b1;
      m_run = 0;
    end
`ifdef EN_COND_HITIME_EN
    if (e.rise)                         m_hi = 1;
    else if (m_level && m_hi != '1)     m_hi = m_hi + 1'b1;
`endif
    e.level  = m_level;
    e.change = e.rise | e.fall;
    e.glitch = m_glitch;
    e.hi     = m_hi;
    sb.push_back(e);
  endtask

  // Drive one raw sample for the next edge, update the model, sample after the edge.
  task automatic tick(input logic raw);
    @(negedge clk);
    en_raw = raw;
    @(posedge clk);
    model_step(raw);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    en_raw = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (got !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", i, got);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_release cyc %0d: got %h want %h", i, got, exp_v);
      end
      n_cmp++;
      if (en_level !== (i == 5)) begin
        n_bad++;
        $display("FAIL reset_latency cyc %0d: en_level %b want %b", i, en_level, (i == 5));
      end
    end
  endtask

  task automatic test_fall();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL fall_hold cyc %0d: got %h want %h", i, got, exp_v);
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick(1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL fall cyc %0d: got %h want %h", i, got, exp_v);
      end
      n_cmp++;
      if (en_fall !== (i == 5) || en_level !== (i < 5)) begin
        n_bad++;
        $display("FAIL fall_latency cyc %0d: fall %b level %b want fall %b level %b",
                 i, en_fall, en_level, (i == 5), (i < 5));
      end
    end
  endtask

  task automatic test_glitch();
    logic pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tick(pat[i]);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL glitch cyc %0d: got %h want %h", i, got, exp_v);
      end
    end
    n_cmp++;
    if (glitch_cnt !== 8'd1 || en_level !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_count: cnt %0d level %b want cnt 1 level 0", glitch_cnt, en_level);
    end
  endtask

  task automatic test_rise();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL rise_idle cyc %0d: got %h want %h", i, got, exp_v);
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick(1'b1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL rise cyc %0d: got %h want %h", i, got, exp_v);
      end
      n_cmp++;
      if (en_rise !== (i == 5) || en_change !== (i == 5) || en_level !== (i >= 5)) begin
        n_bad++;
        $display("FAIL rise_latency cyc %0d: rise %b change %b level %b want rise %b level %b",
                 i, en_rise, en_change, en_level, (i == 5), (i >= 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lens[4] = '{5, 5, 5, 8};
    logic        lvl;
    int unsigned c;
    lvl = 1'b0;
    c   = 0;
    for (int p = 0; p < 4; p++) begin
      for (int unsigned j = 0; j < lens[p]; j++) begin
        tick(lvl);
        exp_v = sb.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
          n_bad++;
          $display("FAIL back_to_back cyc %0d: got %h want %h", c, got, exp_v);
        end
        n_cmp++;
        if (en_rise && en_fall) begin
          n_bad++;
          $display("FAIL rise_fall_overlap cyc %0d: rise %b fall %b want not both", c, en_rise, en_fall);
        end
        c++;
      end
      lvl = ~lvl;
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 608; i++) begin
      tick((i < 8) ? 1'b0 : logic'(i[0]));
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL toggle cyc %0d: got %h want %h", i, got, exp_v);
      end
    end
    n_cmp++;
    if (glitch_cnt !== 8'hFF || en_level !== 1'b0) begin
      n_bad++;
      $display("FAIL toggle_saturate: cnt %0d level %b want cnt 255 level 0", glitch_cnt, en_level);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      tick((i < 4) ? 1'b0 : 1'b1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_pre cyc %0d: got %h want %h", i, got, exp_v);
      end
    end
    // Four high samples taken: FSM sits in DEB_HI with cnt=2.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %h want 0", got);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (got !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset_mid_hold cyc %0d: got %h want 0", i, got);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_post cyc %0d: got %h want %h", i, got, exp_v);
      end
      n_cmp++;
      if (en_rise !== (i == 5)) begin
        n_bad++;
        $display("FAIL reset_mid_latency cyc %0d: rise %b want %b", i, en_rise, (i == 5));
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    en_raw = 1'b0;
    model_reset();
    test_reset();
    test_fall();
    test_glitch();
    test_rise();
    test_back_to_back();
    test_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
